// File: rtl/pcileech_tlps128_tx_arbiter.sv
// Packet-atomic round-robin arbiter that merges several 128-bit TLP sources
// onto the single PCIe TX stream. A grant is held from the first beat until
// the tlast beat is accepted, so TLPs are never interleaved on the sink.
module pcileech_tlps128_tx_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk_pcie,
  input  logic                   rst,
  input  logic [NUM_SRC*128-1:0] src_tdata,
  input  logic [NUM_SRC*4-1:0]   src_tkeepdw,
  input  logic [NUM_SRC-1:0]     src_tlast,
  input  logic [NUM_SRC-1:0]     src_tvalid,
  output logic [NUM_SRC-1:0]     src_tready,
  input  logic [NUM_SRC-1:0]     src_enable,
  output logic [127:0]           snk_tdata,
  output logic [3:0]             snk_tkeepdw,
  output logic                   snk_tlast,
  output logic                   snk_tvalid,
  input  logic                   snk_tready,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy,
  output logic [CNT_W-1:0]       pkt_count
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_XFER = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d;

  logic [127:0]     tdata_a [NUM_SRC];
  logic [3:0]       tkeep_a [NUM_SRC];
  logic [NUM_SRC-1:0] req;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             last_beat;

  // Split the flat source buses into per-source lanes for the output mux.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
    assign tdata_a[g] = src_tdata[g*128 +: 128];
    assign tkeep_a[g] = src_tkeepdw[g*4 +: 4];
  end

  // Only valid and enabled sources compete; enable matters only at grant time.
  assign req = src_tvalid & src_enable;

  // Round-robin search starting just after the last served source.
  // Walking k downwards lets the nearest requester overwrite farther ones.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Sink mux and ready steering, driven only while a packet is in flight.
  always_comb begin
    snk_tdata   = '0;
    snk_tkeepdw = '0;
    snk_tlast   = 1'b0;
    snk_tvalid  = 1'b0;
    src_tready  = '0;
    if (state_q == S_XFER) begin
      snk_tdata   = tdata_a[grant_idx_q];
      snk_tkeepdw = tkeep_a[grant_idx_q];
      snk_tlast   = src_tlast[grant_idx_q];
      snk_tvalid  = src_tvalid[grant_idx_q];
      src_tready[grant_idx_q] = snk_tready;
    end
  end

  assign last_beat = snk_tvalid & snk_tready & snk_tlast;

  // Grant FSM: IDLE picks a source, XFER holds it until tlast is accepted.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    pkt_count_d = pkt_count_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d     = S_XFER;
          grant_idx_d = pick_idx;
        end
      end
      default: begin
        if (last_beat) begin
          state_d     = S_IDLE;
          rr_ptr_d    = grant_idx_q;
          pkt_count_d = pkt_count_q + CNT_W'(1);
        end
      end
    endcase
  end

  // State registers; rr_ptr resets to the top so source 0 is searched first.
  always_ff @(posedge clk_pcie or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= IDX_W'(NUM_SRC - 1);
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign grant_idx = grant_idx_q;
  assign busy      = (state_q == S_XFER);
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_pcileech_tlps128_tx_arbiter.sv
// Bench for the TLP TX arbiter: directed scenarios plus a random run, all
// checked cycle by cycle against a transaction-level reference model.
module tb_pcileech_tlps128_tx_arbiter;
  localparam int N  = 4;
  localparam int CW = 4;   // small counter so the random run exercises wrap

  logic               clk_pcie = 1'b0;
  logic               rst = 1'b1;
  logic [N*128-1:0]   src_tdata = '0;
  logic [N*4-1:0]     src_tkeepdw = '0;
  logic [N-1:0]       src_tlast = '0, src_tvalid = '0, src_tready, src_enable = '0;
  logic [127:0]       snk_tdata;
  logic [3:0]         snk_tkeepdw;
  logic               snk_tlast, snk_tvalid;
  logic               snk_tready = 1'b0;
  logic [1:0]         grant_idx;
  logic               busy;
  logic [CW-1:0]      pkt_count;

  pcileech_tlps128_tx_arbiter #(.NUM_SRC(N), .IDX_W(2), .CNT_W(CW)) dut (
    .clk_pcie(clk_pcie), .rst(rst),
    .src_tdata(src_tdata), .src_tkeepdw(src_tkeepdw), .src_tlast(src_tlast),
    .src_tvalid(src_tvalid), .src_tready(src_tready), .src_enable(src_enable),
    .snk_tdata(snk_tdata), .snk_tkeepdw(snk_tkeepdw), .snk_tlast(snk_tlast),
    .snk_tvalid(snk_tvalid), .snk_tready(snk_tready),
    .grant_idx(grant_idx), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk_pcie = ~clk_pcie;

  // Source-side packet generators
  bit           has_pkt [N];
  int           len [N];
  int           beat [N];
  bit           vm [N];
  logic [127:0] dat [N];
  logic [3:0]   kp [N];
  logic [N-1:0] en;
  bit           sready;

  // Reference model: which source owns the link, who was served last
  bit  m_busy;
  int  m_grant, m_last, m_count;

  int  n_chk, n_pass;
  int  gq[$];
  int  sink_beats;
  bit  prev_busy;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic new_beat(int s);
    dat[s] = {$urandom, $urandom, $urandom, $urandom};
    kp[s]  = 4'($urandom);
  endtask

  task automatic load(int s, int l);
    has_pkt[s] = 1'b1;
    len[s]     = l;
    beat[s]    = 0;
    new_beat(s);
  endtask

  // Called at a negedge: pulse reset, check reset values while it is held.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_cnt", pkt_count, 0);
    chk("rst_tvalid", snk_tvalid, 0);
    chk("rst_tlast", snk_tlast, 0);
    chk("rst_tdata", snk_tdata, 0);
    chk("rst_tkeep", snk_tkeepdw, 0);
    chk("rst_tready", src_tready, 0);
    m_busy = 0; m_grant = 0; m_last = N - 1; m_count = 0;
    for (int s = 0; s < N; s++) has_pkt[s] = 1'b0;
    gq.delete();
    sink_beats = 0;
    prev_busy  = 1'b0;
    @(negedge clk_pcie);
    rst = 1'b0;
  endtask

  // One clock: drive sources, compare DUT with model, advance both.
  task automatic cycle();
    logic [N-1:0] et;
    bit           ev, el;
    logic [127:0] ed;
    logic [3:0]   ek;
    for (int s = 0; s < N; s++) begin
      src_tvalid[s]            = has_pkt[s] & vm[s];
      src_tdata[s*128 +: 128]  = dat[s];
      src_tkeepdw[s*4 +: 4]    = kp[s];
      src_tlast[s]             = has_pkt[s] && (beat[s] == len[s] - 1);
    end
    src_enable = en;
    snk_tready = sready;
    #1;
    et = '0; ev = 0; el = 0; ed = '0; ek = '0;
    if (m_busy) begin
      ev = src_tvalid[m_grant];
      el = src_tlast[m_grant];
      ed = dat[m_grant];
      ek = kp[m_grant];
      et[m_grant] = sready;
    end
    chk("busy", busy, m_busy);
    chk("grant_idx", grant_idx, m_grant);
    chk("pkt_count", pkt_count, m_count % (1 << CW));
    chk("snk_tvalid", snk_tvalid, ev);
    chk("snk_tlast", snk_tlast, el);
    chk("snk_tdata", snk_tdata, ed);
    chk("snk_tkeepdw", snk_tkeepdw, ek);
    chk("src_tready", src_tready, et);
    if (busy && !prev_busy) gq.push_back(int'(grant_idx));
    prev_busy = busy;
    if (snk_tvalid && snk_tready) sink_beats++;
    // sources advance on the handshake they actually see
    for (int s = 0; s < N; s++) begin
      if (src_tvalid[s] && src_tready[s]) begin
        if (beat[s] == len[s] - 1) has_pkt[s] = 1'b0;
        else begin
          beat[s]++;
          new_beat(s);
        end
      end
    end
    // model: finish the owned packet on an accepted last beat, otherwise
    // hand the link to the nearest eligible requester after the last one served
    if (m_busy) begin
      if (src_tvalid[m_grant] && sready && src_tlast[m_grant]) begin
        m_busy  = 0;
        m_last  = m_grant;
        m_count = m_count + 1;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (src_tvalid[i] && en[i]) begin
          m_busy  = 1;
          m_grant = i;
          break;
        end
      end
    end
    @(negedge clk_pcie);
  endtask

  initial begin
    logic [7:0] pat;
    n_chk = 0; n_pass = 0;
    en = '1; sready = 1'b1;
    for (int s = 0; s < N; s++) begin
      vm[s] = 1'b1; has_pkt[s] = 1'b0; len[s] = 1; beat[s] = 0;
      dat[s] = '0; kp[s] = '0;
    end
    @(negedge clk_pcie);
    do_reset();

    // single 3-beat TLP from source 2
    load(2, 3);
    repeat (8) cycle();
    chk("t1_ngrant", gq.size(), 1);
    chk("t1_grant", gq[0], 2);
    chk("t1_beats", sink_beats, 3);
    chk("t1_cnt", pkt_count, 1);

    // three concurrent requesters, round-robin order from reset
    do_reset();
    load(0, 2); load(1, 2); load(3, 2);
    repeat (14) cycle();
    chk("t2_ngrant", gq.size(), 3);
    chk("t2_g0", gq[0], 0);
    chk("t2_g1", gq[1], 1);
    chk("t2_g2", gq[2], 3);
    chk("t2_cnt", pkt_count, 3);

    // sink backpressure pattern 1,0,0,1,1,0,1
    do_reset();
    load(1, 4);
    pat = 8'b1101_1001;
    cycle();
    for (int j = 0; j < 8; j++) begin
      sready = pat[j];
      cycle();
    end
    sready = 1'b1;
    repeat (3) cycle();
    chk("t3_beats", sink_beats, 4);
    chk("t3_cnt", pkt_count, 1);

    // enable masking: source 0 masked, source 1 masked mid-packet
    do_reset();
    en = 4'b1110;
    load(0, 2); load(1, 3);
    cycle();
    cycle();
    en = 4'b1100;
    repeat (6) cycle();
    load(1, 2);
    repeat (10) cycle();
    chk("t4_ngrant", gq.size(), 1);
    chk("t4_grant", gq[0], 1);
    chk("t4_src0_pend", has_pkt[0], 1);
    chk("t4_src1_pend", has_pkt[1], 1);
    chk("t4_cnt", pkt_count, 1);
    en = '1;

    // granted source stalls for 50 cycles; source 3 must wait
    do_reset();
    load(0, 3); load(3, 2);
    cycle();
    cycle();
    vm[0] = 1'b0;
    repeat (50) cycle();
    chk("t5_hold_grant", grant_idx, 0);
    chk("t5_hold_busy", busy, 1);
    vm[0] = 1'b1;
    repeat (10) cycle();
    chk("t5_ngrant", gq.size(), 2);
    chk("t5_g0", gq[0], 0);
    chk("t5_g1", gq[1], 3);
    chk("t5_cnt", pkt_count, 2);

    // reset during beat 2 of a 3-beat packet
    do_reset();
    load(0, 3); load(1, 3);
    cycle();
    cycle();
    chk("t6_mid_busy", busy, 1);
    do_reset();
    load(0, 2);
    repeat (6) cycle();
    chk("t6_grant", gq[0], 0);
    chk("t6_cnt", pkt_count, 1);

    // random traffic with random bubbles, backpressure and enables
    do_reset();
    repeat (3000) begin
      for (int s = 0; s < N; s++) begin
        if (!has_pkt[s] && $urandom_range(3) == 0) load(s, $urandom_range(1, 4));
        vm[s] = ($urandom_range(9) != 0);
      end
      sready = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) en = N'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pcileech_tlps128_tx_arbiter.md
Name: pcileech_tlps128_tx_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares the single 128-bit PCIe TX TLP stream between several TLP sources: config-space responder, BAR responder and the FIFO/host TLP path.
- Sits between the TLP producers and the PCIe core TX interface, in the PCIe clock domain.
- Once a source is granted, it keeps the grant until its tlast beat is accepted. TLPs are never interleaved.
- Provides per-source enable masking at packet boundaries, plus grant/packet status for debug.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8)
- IDX_W, 2, width of grant index; must equal $clog2(NUM_SRC)
- CNT_W, 16, width of the total accepted-packet counter

Ports:
- clk_pcie  in  1  PCIe user clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- src_tdata  in  NUM_SRC*128  per-source TLP data; source i at [i*128 +: 128]
- src_tkeepdw  in  NUM_SRC*4  per-source DWORD keep
- src_tlast  in  NUM_SRC  per-source end-of-TLP
- src_tvalid  in  NUM_SRC  per-source valid
- src_tready  out  NUM_SRC  per-source ready
- src_enable  in  NUM_SRC  1 = source eligible for new grants
- snk_tdata  out  128  muxed TLP data to PCIe core
- snk_tkeepdw  out  4  muxed keep
- snk_tlast  out  1  muxed last
- snk_tvalid  out  1  muxed valid
- snk_tready  in  1  PCIe core ready
- grant_idx  out  IDX_W  currently/last granted source
- busy  out  1  1 while a packet is in progress (state XFER)
- pkt_count  out  CNT_W  total packets completed, wraps modulo 2^CNT_W

Behaviour:
- Reset values:
  - State IDLE; rr_ptr = NUM_SRC-1, so the first search starts at source 0.
  - grant_idx = 0, busy = 0, pkt_count = 0.
  - snk_tvalid = 0, snk_tlast = 0, snk_tdata = 0, snk_tkeepdw = 0, all src_tready = 0.
- FSM states: IDLE, XFER.
- IDLE:
  - req[i] = src_tvalid[i] & src_enable[i].
  - If any req is set, pick the first set index searching rr_ptr+1, rr_ptr+2, … modulo NUM_SRC.
  - Register the pick into grant_idx, go to XFER, busy=1.
  - Grant takes 1 cycle; no data moves in IDLE; all src_tready = 0 and snk_tvalid = 0.
- XFER data path (combinational from registered grant_idx):
  - snk_tdata/tkeepdw/tlast/tvalid = fields of source grant_idx.
  - src_tready[grant_idx] = snk_tready; all other src_tready = 0.
  - A beat transfers when snk_tvalid & snk_tready.
- XFER exit:
  - On a transfer beat with tlast=1: go to IDLE, rr_ptr <= grant_idx, pkt_count += 1, busy=0 next cycle.
  - A new grant follows one cycle later. The inter-packet gap is exactly 1 cycle when other requests are pending.
- The granted source may drop tvalid mid-packet. The grant is held indefinitely: no timeout, no preemption, and snk_tvalid follows the source.
- Deasserting src_enable of the granted source mid-packet has no effect until tlast. It only blocks future grants.
- src_enable is sampled only in IDLE. A source with tvalid=1 and enable=0 is skipped, and its tready stays 0.
- A single-beat TLP (tvalid & tlast in the first XFER beat) completes in one XFER cycle.
- snk_tready=0 stalls the beat: all outputs hold, tready to the source stays 0, and the state is unchanged.
- Fairness: with all NUM_SRC sources continuously requesting, grants cycle 0,1,…,NUM_SRC-1,0. No source waits more than NUM_SRC-1 packets.
- grant_idx holds its value in IDLE until the next grant.
- Asynchronous reset mid-packet: returns to reset values immediately. A truncated packet on the sink is accepted; the upstream PCIe reset covers it.
- pkt_count wraps from 2^CNT_W-1 to 0 without a flag.

Test Plan:
- Reset, then source 2 sends a 3-beat TLP with snk_tready=1 -> grant_idx=2 one cycle after tvalid; 3 beats pass unmodified with tlast on beat 3; pkt_count=1; busy returns to 0.
- Sources 0,1,3 each hold a 2-beat TLP at once -> grant order 0,1,3; one idle cycle between packets; never interleaved; pkt_count=3.
- Source 1 sends 4 beats while snk_tready toggles 1,0,0,1,1,0,1 -> exactly 4 beats delivered in order; source 1 tready mirrors snk_tready; data stable while stalled.
- src_enable=4'b1110 and source 0 requesting -> source 0 never granted (tready stays 0). Clear src_enable[1] during source 1's packet -> that packet completes and source 1 then gets no new grant.
- Source 0 drops tvalid for 50 cycles mid-packet while source 3 requests -> grant stays 0; snk_tvalid=0 during the gap; source 3 granted only after source 0's tlast.
- Assert rst during beat 2 of a 3-beat packet -> all outputs at reset values the same cycle; after release, source 0 (if requesting) is granted first and pkt_count=0.
